// File: rtl/memory_client_if.sv
// Request/response bus between a requester and memory_client.
// The master issues read/write requests; the slave answers reads with data or an error.
interface memory_client_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, resp_error
    );
endinterface

// File: rtl/memory_client.sv
// memory_client: host end of the UART memory protocol (read: 0x01,addr -> one reply byte; write: 0x02,addr,data).
// Define MEMORY_CLIENT_TIMEOUT_EN to abandon unanswered reads after TIMEOUT_CYCLES with a resp_error pulse.
module memory_client #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1200000
) (
    input  logic           clk,
    input  logic           rst,
    memory_client_if.slave bus,
    output logic           transmit,
    output logic [7:0]     tx_byte,
    input  logic           is_transmitting,
    input  logic           received,
    input  logic [7:0]     rx_byte
);
    // state     | meaning
    // IDLE      | ready for a request
    // SEND      | waiting for the UART to be free, then pulse transmit
    // DRAIN     | waiting for the busy period of the byte just sent to end
    // WAIT_RESP | read sent, waiting for the reply byte
    typedef enum logic [1:0] {IDLE, SEND, DRAIN, WAIT_RESP} state_t;

    state_t     state;
    logic       ready_q;
    logic       resp_valid_q;
    logic [7:0] resp_data_q;
    logic       seen_busy;
    logic       write_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [1:0] idx;
    logic [7:0] next_byte;
    logic       last_byte;

    assign last_byte = write_q ? (idx == 2'd2) : (idx == 2'd1);

    always_comb begin
        case (idx)
            2'd0:    next_byte = write_q ? 8'h02 : 8'h01;
            2'd1:    next_byte = addr_q;
            default: next_byte = wdata_q;
        endcase
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

`ifdef MEMORY_CLIENT_TIMEOUT_EN
    logic        error_q;
    logic [23:0] wait_cnt;
    assign bus.resp_error = error_q;
`else
    assign bus.resp_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ready_q      <= 1'b0;
            transmit     <= 1'b0;
            tx_byte      <= 8'h00;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 8'h00;
            seen_busy    <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            idx          <= 2'd0;
`ifdef MEMORY_CLIENT_TIMEOUT_EN
            error_q      <= 1'b0;
            wait_cnt     <= 24'd0;
`endif
        end else begin
            transmit     <= 1'b0;
            resp_valid_q <= 1'b0;
`ifdef MEMORY_CLIENT_TIMEOUT_EN
            error_q      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (bus.req_valid && ready_q) begin
                        write_q <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        idx     <= 2'd0;
                        ready_q <= 1'b0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (!is_transmitting) begin
                        transmit  <= 1'b1;
                        tx_byte   <= next_byte;
                        seen_busy <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A byte is finished only after its busy period has been observed to start and end.
                    if (is_transmitting) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        if (!last_byte) begin
                            idx   <= idx + 2'd1;
                            state <= SEND;
                        end else if (write_q) begin
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end else begin
`ifdef MEMORY_CLIENT_TIMEOUT_EN
                            wait_cnt <= 24'd0;
`endif
                            state <= WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (received) begin
                        resp_data_q  <= rx_byte;
                        resp_valid_q <= 1'b1;
                        ready_q      <= 1'b1;
                        state        <= IDLE;
                    end
`ifdef MEMORY_CLIENT_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_CYCLES - 24'd1) begin
                        error_q <= 1'b1;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 24'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/memory_client.md
MEMORY_CLIENT -- requirements
Module: memory_client

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd1200000, cycles waited for a read response before abandoning (100 ms at 12 MHz).
REQ-002 clk  input  1  master clock; all logic on posedge clk.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  8  memory address.
REQ-008 req_wdata  input  8  write data; ignored for reads.
REQ-009 resp_valid  output  1  one-cycle pulse: resp_data holds the read result.
REQ-010 resp_data  output  8  read result; holds its value until the next resp_valid.
REQ-011 resp_error  output  1  one-cycle pulse: read timed out.
REQ-012 transmit  output  1  one-cycle pulse to the UART: send tx_byte.
REQ-013 tx_byte  output  8  byte to send; stable from the transmit pulse until the next transmit pulse.
REQ-014 is_transmitting  input  1  UART transmitter busy.
REQ-015 received  input  1  UART one-cycle pulse: rx_byte is valid.
REQ-016 rx_byte  input  8  received byte.

Function
REQ-017 The block SHALL act as the host end of the UART memory protocol: a read is bytes 0x01, addr; the responder answers with one data byte; a write is bytes 0x02, addr, data; a write has no response.
REQ-018 States SHALL be IDLE, SEND, DRAIN, WAIT_RESP.
REQ-019 req_ready SHALL be 1 only in IDLE, never while rst=1.
REQ-020 On a clock edge with req_valid=1 and req_ready=1, the block SHALL latch req_write, req_addr and req_wdata, set byte index 0, and enter SEND.
REQ-021 In SEND with is_transmitting=0, the block SHALL pulse transmit for one cycle with tx_byte = (index0: 0x01 for a read, 0x02 for a write; index1: addr; index2: wdata), then enter DRAIN.
REQ-022 In SEND with is_transmitting=1, the block SHALL hold without pulsing transmit.
REQ-023 DRAIN SHALL wait until is_transmitting has been seen at 1 and then at 0.
- On exit with bytes remaining (2 for a read, 3 for a write), the block SHALL increment the index and return to SEND.
- After the final write byte, it SHALL return to IDLE.
- After the final read byte, it SHALL enter WAIT_RESP.
REQ-024 Minimum latency SHALL be one cycle from request acceptance to the first transmit pulse.
REQ-025 In WAIT_RESP, on received=1 the block SHALL register rx_byte into resp_data, pulse resp_valid on the following cycle, and return to IDLE.
REQ-026 Bytes received in any state other than WAIT_RESP SHALL be ignored.
REQ-027 A received pulse in the same cycle as a WAIT_RESP entry SHALL be ignored; the response is only accepted from the first cycle spent in WAIT_RESP.
REQ-028 The block SHALL issue at most one transmit pulse per byte and exactly 2 (read) or 3 (write) pulses per request.
REQ-029 resp_valid and resp_error SHALL never assert in the same cycle.

Reset
REQ-030 While rst=1, the block SHALL drive: state IDLE, req_ready 0, transmit 0, resp_valid 0, resp_error 0, tx_byte 0x00, resp_data 0x00, byte index and timeout counter 0.
REQ-031 Reset mid-request SHALL abandon the request silently, with no resp_valid or resp_error; resynchronising the responder is the system's responsibility.
REQ-032 req_ready SHALL rise on the first cycle after rst falls.

Configuration
REQ-033 With MEMORY_CLIENT_TIMEOUT_EN defined:
- a counter SHALL clear on WAIT_RESP entry and increment each cycle spent in WAIT_RESP;
- on reaching TIMEOUT_CYCLES without received=1, the block SHALL pulse resp_error for one cycle and return to IDLE;
- if received=1 and expiry occur in the same cycle, received SHALL win.
REQ-034 Without MEMORY_CLIENT_TIMEOUT_EN, WAIT_RESP SHALL wait indefinitely, resp_error SHALL be tied to 0, and no counter SHALL be synthesised.

Verification
REQ-035 Write request addr=0x10 wdata=0xA5 -> transmit pulses carrying 0x02, 0x10, 0xA5, each pulse only after the previous is_transmitting busy period ends; returns to IDLE with no resp_valid.
REQ-036 Read request addr=0x10, UART model replies 0x5C -> transmits 0x01, 0x10; one resp_valid pulse with resp_data=0x5C; req_ready high again the same cycle.
REQ-037 Stray received=1 with rx_byte=0x77 in IDLE and during SEND -> no resp_valid, state unchanged; a later genuine reply is still delivered correctly.
REQ-038 is_transmitting held at 1 for 50 cycles at request acceptance -> no transmit pulse until it falls; exactly one pulse per byte.
REQ-039 rst asserted in DRAIN after the addr byte of a write -> no further transmit pulse; all outputs at reset values; a new request is accepted normally.
REQ-040 MEMORY_CLIENT_TIMEOUT_EN defined with TIMEOUT_CYCLES=100, read with no reply -> resp_error pulses exactly once after 100 WAIT_RESP cycles; without the macro, the block remains in WAIT_RESP and resp_error stays 0.
